// File: rtl/exec_pipe_pkg.sv
// Shared types for the multi-latency execution lane: ALU opcodes, drain FSM states
// and the legal range of the result pipeline depth.
package exec_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_IDLE   = 2'd2
  } drain_state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;

  function automatic logic latency_legal(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/exec_pipe_alu.sv
// Purely combinational integer ALU for one execution lane; results wrap to DATA_W.
module exec_pipe_alu
  import exec_pipe_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  alu_op_e           op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int SHW = $clog2(DATA_W);

  logic [SHW-1:0] shamt_s;
  logic           slt_s;

  assign shamt_s = src2_i[SHW-1:0];
  assign slt_s   = $signed(src1_i) < $signed(src2_i);

  // Opcode decode
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = src1_i + src2_i;
      OP_SUB:  result_o = src1_i - src2_i;
      OP_AND:  result_o = src1_i & src2_i;
      OP_OR:   result_o = src1_i | src2_i;
      OP_XOR:  result_o = src1_i ^ src2_i;
      OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, slt_s};
      OP_SLL:  result_o = src1_i << shamt_s;
      OP_SRL:  result_o = src1_i >> shamt_s;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_pipe_multilat.sv
// One issue lane: bypass operand select, RR/EX register, ALU, LATENCY-deep result
// pipeline, drain/idle FSM for lane shutdown and a completed-op counter.
module exec_pipe_multilat
  import exec_pipe_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int TAG_W      = 7,
  parameter int AL_W       = 7,
  parameter int NUM_BYPASS = 4,
  parameter int LATENCY    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         recover_i,
  input  logic                         exception_i,
  input  logic                         lane_active_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [2:0]                   issue_op_i,
  input  logic [TAG_W-1:0]             issue_phySrc1_i,
  input  logic [TAG_W-1:0]             issue_phySrc2_i,
  input  logic [TAG_W-1:0]             issue_phyDest_i,
  input  logic [AL_W-1:0]              issue_alId_i,
  output logic [TAG_W-1:0]             phySrc1_o,
  output logic [TAG_W-1:0]             phySrc2_o,
  input  logic [DATA_W-1:0]            src1Data_i,
  input  logic [DATA_W-1:0]            src2Data_i,
  input  logic [NUM_BYPASS-1:0]        bypassValid_i,
  input  logic [NUM_BYPASS*TAG_W-1:0]  bypassTag_i,
  input  logic [NUM_BYPASS*DATA_W-1:0] bypassData_i,
  output logic                         bypassValid_o,
  output logic [TAG_W-1:0]             bypassTag_o,
  output logic [DATA_W-1:0]            bypassData_o,
  output logic                         ctrlValid_o,
  output logic [AL_W-1:0]              ctrlAlId_o,
  output logic                         drain_done_o,
  output logic [31:0]                  opCount_o
);

  if (!latency_legal(LATENCY)) begin : g_latency_illegal
    $error("exec_pipe_multilat: LATENCY out of range");
  end

  drain_state_e      state_q, state_d;
  logic              flush_s, accept_s, pipe_empty_s;
  logic [DATA_W-1:0] src1_sel_s, src2_sel_s, alu_result_s;

  logic              rrex_valid_q, rrex_valid_d;
  alu_op_e           rrex_op_q, rrex_op_d;
  logic [DATA_W-1:0] rrex_src1_q, rrex_src1_d, rrex_src2_q, rrex_src2_d;
  logic [TAG_W-1:0]  rrex_dest_q, rrex_dest_d;
  logic [AL_W-1:0]   rrex_alid_q, rrex_alid_d;

  logic [LATENCY:1]  p_valid_q, p_valid_d;
  logic [DATA_W-1:0] p_data_q [1:LATENCY];
  logic [DATA_W-1:0] p_data_d [1:LATENCY];
  logic [TAG_W-1:0]  p_tag_q  [1:LATENCY];
  logic [TAG_W-1:0]  p_tag_d  [1:LATENCY];
  logic [AL_W-1:0]   p_alid_q [1:LATENCY];
  logic [AL_W-1:0]   p_alid_d [1:LATENCY];
  logic [31:0]       op_count_q, op_count_d;

  assign flush_s   = recover_i | exception_i;
  assign accept_s  = issue_valid_i && (state_q == ST_ACTIVE) && !flush_s;
  assign phySrc1_o = issue_phySrc1_i;
  assign phySrc2_o = issue_phySrc2_i;

  // Bypass select: walk channels high to low so the lowest matching index wins
  always_comb begin
    src1_sel_s = src1Data_i;
    src2_sel_s = src2Data_i;
    for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
      src1_sel_s = (bypassValid_i[k] && (bypassTag_i[k*TAG_W +: TAG_W] == issue_phySrc1_i))
                   ? bypassData_i[k*DATA_W +: DATA_W] : src1_sel_s;
      src2_sel_s = (bypassValid_i[k] && (bypassTag_i[k*TAG_W +: TAG_W] == issue_phySrc2_i))
                   ? bypassData_i[k*DATA_W +: DATA_W] : src2_sel_s;
    end
  end

  // RR/EX next state: payload only moves on an accepted packet
  always_comb begin
    rrex_valid_d = 1'b0;
    rrex_op_d    = rrex_op_q;
    rrex_src1_d  = rrex_src1_q;
    rrex_src2_d  = rrex_src2_q;
    rrex_dest_d  = rrex_dest_q;
    rrex_alid_d  = rrex_alid_q;
    if (accept_s) begin
      rrex_valid_d = 1'b1;
      rrex_op_d    = alu_op_e'(issue_op_i);
      rrex_src1_d  = src1_sel_s;
      rrex_src2_d  = src2_sel_s;
      rrex_dest_d  = issue_phyDest_i;
      rrex_alid_d  = issue_alId_i;
    end else begin
      rrex_valid_d = 1'b0;
    end
  end

  exec_pipe_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (rrex_op_q),
    .src1_i   (rrex_src1_q),
    .src2_i   (rrex_src2_q),
    .result_o (alu_result_s)
  );

  // Result pipeline: payload follows valid only, so outputs hold while idle or flushed
  always_comb begin
    p_valid_d = '0;
    p_data_d  = p_data_q;
    p_tag_d   = p_tag_q;
    p_alid_d  = p_alid_q;
    if (!flush_s) begin
      p_valid_d[1] = rrex_valid_q;
      p_data_d[1]  = rrex_valid_q ? alu_result_s : p_data_q[1];
      p_tag_d[1]   = rrex_valid_q ? rrex_dest_q  : p_tag_q[1];
      p_alid_d[1]  = rrex_valid_q ? rrex_alid_q  : p_alid_q[1];
      for (int k = 2; k <= LATENCY; k++) begin
        p_valid_d[k] = p_valid_q[k-1];
        p_data_d[k]  = p_valid_q[k-1] ? p_data_q[k-1] : p_data_q[k];
        p_tag_d[k]   = p_valid_q[k-1] ? p_tag_q[k-1]  : p_tag_q[k];
        p_alid_d[k]  = p_valid_q[k-1] ? p_alid_q[k-1] : p_alid_q[k];
      end
    end else begin
      p_valid_d = '0;
    end
  end

  assign op_count_d   = (p_valid_q[LATENCY] && !flush_s) ? op_count_q + 32'd1 : op_count_q;
  // Emptiness is judged on next-cycle contents so IDLE follows the last completion directly
  assign pipe_empty_s = !rrex_valid_d && (p_valid_d == '0);

  // Drain FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE: begin
        if (!lane_active_i) state_d = ST_DRAIN;
        else                state_d = ST_ACTIVE;
      end
      ST_DRAIN: begin
        if (pipe_empty_s)       state_d = ST_IDLE;
        else if (lane_active_i) state_d = ST_ACTIVE;
        else                    state_d = ST_DRAIN;
      end
      ST_IDLE: begin
        if (lane_active_i) state_d = ST_ACTIVE;
        else               state_d = ST_IDLE;
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // State, pipeline and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ACTIVE;
      rrex_valid_q <= 1'b0;
      rrex_op_q    <= OP_ADD;
      rrex_src1_q  <= '0;
      rrex_src2_q  <= '0;
      rrex_dest_q  <= '0;
      rrex_alid_q  <= '0;
      p_valid_q    <= '0;
      for (int k = 1; k <= LATENCY; k++) begin
        p_data_q[k] <= '0;
        p_tag_q[k]  <= '0;
        p_alid_q[k] <= '0;
      end
      op_count_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      rrex_valid_q <= rrex_valid_d;
      rrex_op_q    <= rrex_op_d;
      rrex_src1_q  <= rrex_src1_d;
      rrex_src2_q  <= rrex_src2_d;
      rrex_dest_q  <= rrex_dest_d;
      rrex_alid_q  <= rrex_alid_d;
      p_valid_q    <= p_valid_d;
      p_data_q     <= p_data_d;
      p_tag_q      <= p_tag_d;
      p_alid_q     <= p_alid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign issue_ready_o = (state_q == ST_ACTIVE);
  assign drain_done_o  = (state_q == ST_IDLE);
  assign bypassValid_o = p_valid_q[LATENCY];
  assign bypassTag_o   = p_tag_q[LATENCY];
  assign bypassData_o  = p_data_q[LATENCY];
  assign ctrlValid_o   = p_valid_q[LATENCY];
  assign ctrlAlId_o    = p_alid_q[LATENCY];
  assign opCount_o     = op_count_q;

endmodule

// File: tb/tb_exec_pipe_multilat.sv
// Directed self-checking bench for exec_pipe_multilat at LATENCY=3. Inputs are driven
// and outputs observed on the falling edge; cycle c is the c-th falling edge of a test.
module tb_exec_pipe_multilat;
  import exec_pipe_pkg::*;

  logic        clk, reset;
  logic        recover_i, exception_i, lane_active_i, issue_valid_i, issue_ready_o;
  logic [2:0]  issue_op_i;
  logic [6:0]  issue_phySrc1_i, issue_phySrc2_i, issue_phyDest_i, issue_alId_i;
  logic [6:0]  phySrc1_o, phySrc2_o;
  logic [63:0] src1Data_i, src2Data_i;
  logic [3:0]  bypassValid_i;
  logic [27:0] bypassTag_i;
  logic [255:0] bypassData_i;
  logic        bypassValid_o, ctrlValid_o, drain_done_o;
  logic [6:0]  bypassTag_o, ctrlAlId_o;
  logic [63:0] bypassData_o;
  logic [31:0] opCount_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 32'd0;

  exec_pipe_multilat #(
    .DATA_W(64), .TAG_W(7), .AL_W(7), .NUM_BYPASS(4), .LATENCY(3)
  ) dut (
    .clk(clk), .reset(reset), .recover_i(recover_i), .exception_i(exception_i),
    .lane_active_i(lane_active_i), .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_phySrc1_i(issue_phySrc1_i), .issue_phySrc2_i(issue_phySrc2_i),
    .issue_phyDest_i(issue_phyDest_i), .issue_alId_i(issue_alId_i),
    .phySrc1_o(phySrc1_o), .phySrc2_o(phySrc2_o),
    .src1Data_i(src1Data_i), .src2Data_i(src2Data_i),
    .bypassValid_i(bypassValid_i), .bypassTag_i(bypassTag_i), .bypassData_i(bypassData_i),
    .bypassValid_o(bypassValid_o), .bypassTag_o(bypassTag_o), .bypassData_o(bypassData_o),
    .ctrlValid_o(ctrlValid_o), .ctrlAlId_o(ctrlAlId_o),
    .drain_done_o(drain_done_o), .opCount_o(opCount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_issue();
    issue_valid_i   = 1'b0;
    issue_op_i      = 3'd0;
    issue_phySrc1_i = 7'h05;
    issue_phySrc2_i = 7'h06;
    issue_phyDest_i = 7'h00;
    issue_alId_i    = 7'h00;
    src1Data_i      = 64'd0;
    src2Data_i      = 64'd0;
    bypassValid_i   = 4'b0000;
    recover_i       = 1'b0;
    exception_i     = 1'b0;
  endtask

  task automatic drive_issue(input logic [2:0] op, input logic [63:0] d1, input logic [63:0] d2,
                             input logic [6:0] dest, input logic [6:0] alid);
    issue_valid_i   = 1'b1;
    issue_op_i      = op;
    issue_phySrc1_i = 7'h05;
    issue_phySrc2_i = 7'h06;
    issue_phyDest_i = dest;
    issue_alId_i    = alid;
    src1Data_i      = d1;
    src2Data_i      = d2;
  endtask

  // Issue one op, expect it on the outputs 4 cycles later and counted one cycle after that
  task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [3:0] bv, input logic [63:0] exp);
    @(negedge clk);
    drive_issue(op, d1, d2, 7'h12, 7'h03);
    bypassValid_i = bv;
    @(negedge clk);
    clear_issue();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bypassValid_o !== 1'b0) begin
        errors++; $display("FAIL %s early_valid: got %b expected 0", name, bypassValid_o);
      end
    end
    @(negedge clk);
    checks++;
    if (bypassValid_o !== 1'b1 || bypassData_o !== exp) begin
      errors++;
      $display("FAIL %s result: got valid %b data %h expected valid 1 data %h",
               name, bypassValid_o, bypassData_o, exp);
    end
    exp_count = exp_count + 32'd1;
    @(negedge clk);
    checks++;
    if (opCount_o !== exp_count) begin
      errors++; $display("FAIL %s count: got %0d expected %0d", name, opCount_o, exp_count);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bypassValid_o !== 1'b0 || ctrlValid_o !== 1'b0 || bypassTag_o !== 7'h00 ||
        bypassData_o !== 64'd0 || ctrlAlId_o !== 7'h00 || opCount_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v%b cv%b tag %h data %h al %h cnt %0d expected all 0",
               bypassValid_o, ctrlValid_o, bypassTag_o, bypassData_o, ctrlAlId_o, opCount_o);
    end
    checks++;
    if (issue_ready_o !== 1'b1 || drain_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_fsm: got ready %b done %b expected ready 1 done 0",
               issue_ready_o, drain_done_o);
    end
    reset = 1'b1;
  endtask

  task automatic test_add();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (bypassValid_o !== 1'b1 || bypassTag_o !== 7'h12 || bypassData_o !== 64'd12) begin
          errors++;
          $display("FAIL add_bypass: got v%b tag %h data %h expected v1 tag 12 data c",
                   bypassValid_o, bypassTag_o, bypassData_o);
        end
        checks++;
        if (ctrlValid_o !== 1'b1 || ctrlAlId_o !== 7'h03 || opCount_o !== 32'd0) begin
          errors++;
          $display("FAIL add_ctrl: got cv%b al %h cnt %0d expected cv1 al 3 cnt 0",
                   ctrlValid_o, ctrlAlId_o, opCount_o);
        end
      end else if (c == 5) begin
        checks++;
        if (bypassValid_o !== 1'b0 || bypassTag_o !== 7'h12 || bypassData_o !== 64'd12 ||
            opCount_o !== 32'd1) begin
          errors++;
          $display("FAIL add_hold: got v%b tag %h data %h cnt %0d expected v0 tag 12 data c cnt 1",
                   bypassValid_o, bypassTag_o, bypassData_o, opCount_o);
        end
      end else begin
        checks++;
        if (bypassValid_o !== 1'b0) begin
          errors++; $display("FAIL add_early c%0d: got %b expected 0", c, bypassValid_o);
        end
      end
      clear_issue();
      if (c == 0) begin
        drive_issue(OP_ADD, 64'd5, 64'd7, 7'h12, 7'h03);
        #1;
        checks++;
        if (phySrc1_o !== 7'h05 || phySrc2_o !== 7'h06) begin
          errors++;
          $display("FAIL rf_addr: got %h %h expected 05 06", phySrc1_o, phySrc2_o);
        end
      end
    end
    exp_count = 32'd1;
  endtask

  task automatic test_bypass();
    run_op("byp_ch1_over_ch3", OP_OR, 64'hF, 64'd0, 4'b1010, 64'hA);
    run_op("byp_ch3_only",     OP_OR, 64'hF, 64'd0, 4'b1000, 64'hB);
    run_op("byp_ch2_over_ch3", OP_OR, 64'hF, 64'd0, 4'b1100, 64'hC);
    run_op("byp_none",         OP_OR, 64'hF, 64'd0, 4'b0000, 64'hF);
    run_op("byp_src2_ch0",     OP_OR, 64'hF, 64'd0, 4'b0001, 64'h10F);
  endtask

  task automatic test_ops();
    run_op("sub_wrap",  OP_SUB, 64'd3, 64'd5, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("slt_true",  OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 64'd1);
    run_op("slt_false", OP_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 64'd0);
    run_op("srl_63",    OP_SRL, 64'h8000_0000_0000_0000, 64'd63, 4'b0000, 64'd1);
    run_op("sll_64",    OP_SLL, 64'd1, 64'd64, 4'b0000, 64'd1);
    run_op("and",       OP_AND, 64'hF0F0, 64'hFF00, 4'b0000, 64'hF000);
    run_op("xor",       OP_XOR, 64'hFF, 64'h0F, 4'b0000, 64'hF0);
  endtask

  task automatic test_throughput();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bypassValid_o !== 1'((c >= 4) && (c <= 6))) begin
        errors++; $display("FAIL tput_valid c%0d: got %b", c, bypassValid_o);
      end
      if ((c >= 4) && (c <= 6)) begin
        checks++;
        if (bypassTag_o !== 7'(44 + c) || bypassData_o !== 64'(2 * c - 6)) begin
          errors++;
          $display("FAIL tput_data c%0d: got tag %h data %h expected tag %h data %h",
                   c, bypassTag_o, bypassData_o, 7'(44 + c), 64'(2 * c - 6));
        end
      end
      clear_issue();
      if (c < 3) drive_issue(OP_ADD, 64'(c + 1), 64'(c + 1), 7'(48 + c), 7'(c));
    end
    exp_count = exp_count + 32'd3;
    checks++;
    if (opCount_o !== exp_count) begin
      errors++; $display("FAIL tput_count: got %0d expected %0d", opCount_o, exp_count);
    end
  endtask

  // recover in cycle 2 kills op0 (in P1) and op1 (in RR/EX) and drops op2; op3 survives
  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bypassValid_o !== 1'(c == 7)) begin
        errors++; $display("FAIL b2b_valid c%0d: got %b", c, bypassValid_o);
      end
      if (c == 7) begin
        checks++;
        if (bypassTag_o !== 7'h23 || bypassData_o !== 64'd6 || ctrlAlId_o !== 7'h13) begin
          errors++;
          $display("FAIL b2b_survivor: got tag %h data %h al %h expected 23 6 13",
                   bypassTag_o, bypassData_o, ctrlAlId_o);
        end
      end
      clear_issue();
      if (c < 4) drive_issue(OP_ADD, 64'(c), 64'(c), 7'(32 + c), 7'(16 + c));
      recover_i = (c == 2);
    end
    exp_count = exp_count + 32'd1;
    checks++;
    if (opCount_o !== exp_count) begin
      errors++; $display("FAIL b2b_count: got %0d expected %0d", opCount_o, exp_count);
    end
  endtask

  // Flush while a result sits at the output: still visible that cycle, never counted
  task automatic test_flush_at_output();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (bypassValid_o !== 1'(c == 4)) begin
        errors++; $display("FAIL flushout_valid c%0d: got %b", c, bypassValid_o);
      end
      clear_issue();
      if (c == 0) drive_issue(OP_ADD, 64'd1, 64'd1, 7'h40, 7'h01);
      exception_i = (c == 4);
    end
    checks++;
    if (opCount_o !== exp_count) begin
      errors++; $display("FAIL flushout_count: got %0d expected %0d", opCount_o, exp_count);
    end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (issue_ready_o !== 1'((c <= 1) || (c >= 9))) begin
        errors++; $display("FAIL drain_ready c%0d: got %b", c, issue_ready_o);
      end
      checks++;
      if (drain_done_o !== 1'((c >= 6) && (c <= 8))) begin
        errors++; $display("FAIL drain_done c%0d: got %b", c, drain_done_o);
      end
      checks++;
      if (bypassValid_o !== 1'((c == 4) || (c == 5))) begin
        errors++; $display("FAIL drain_valid c%0d: got %b", c, bypassValid_o);
      end
      clear_issue();
      if (c == 0 || c == 1 || c == 3) drive_issue(OP_ADD, 64'd2, 64'd2, 7'(80 + c), 7'(c));
      lane_active_i = (c == 0) || (c >= 8);
    end
    exp_count = exp_count + 32'd2;
    checks++;
    if (opCount_o !== exp_count) begin
      errors++; $display("FAIL drain_count: got %0d expected %0d", opCount_o, exp_count);
    end
  endtask

  // One-cycle deassert with an op in flight: DRAIN then straight back to ACTIVE
  task automatic test_drain_abort();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (issue_ready_o !== 1'(c != 1) || drain_done_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_fsm c%0d: got ready %b done %b", c, issue_ready_o, drain_done_o);
      end
      checks++;
      if (bypassValid_o !== 1'(c == 4)) begin
        errors++; $display("FAIL abort_valid c%0d: got %b", c, bypassValid_o);
      end
      clear_issue();
      if (c == 0) drive_issue(OP_ADD, 64'd3, 64'd3, 7'h60, 7'h02);
      lane_active_i = (c != 0);
    end
    exp_count = exp_count + 32'd1;
  endtask

  task automatic test_drain_empty();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (issue_ready_o !== 1'((c == 0) || (c >= 3)) || drain_done_o !== 1'(c == 2)) begin
        errors++;
        $display("FAIL empty_drain c%0d: got ready %b done %b", c, issue_ready_o, drain_done_o);
      end
      clear_issue();
      lane_active_i = (c >= 2);
    end
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clear_issue();
      if (c < 3) drive_issue(OP_ADD, 64'd4, 64'd4, 7'(112 + c), 7'(c));
    end
    checks++;
    if (bypassValid_o !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got %b expected 1", bypassValid_o);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bypassValid_o !== 1'b0 || ctrlValid_o !== 1'b0 || bypassTag_o !== 7'h00 ||
        bypassData_o !== 64'd0 || ctrlAlId_o !== 7'h00 || opCount_o !== 32'd0) begin
      errors++;
      $display("FAIL midrst_async: got v%b cv%b tag %h data %h al %h cnt %0d expected all 0",
               bypassValid_o, ctrlValid_o, bypassTag_o, bypassData_o, ctrlAlId_o, opCount_o);
    end
    exp_count = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bypassValid_o !== 1'b0 || opCount_o !== exp_count) begin
        errors++;
        $display("FAIL midrst_after c%0d: got v%b cnt %0d expected v0 cnt 0",
                 c, bypassValid_o, opCount_o);
      end
    end
  endtask

  initial begin
    reset         = 1'b0;
    lane_active_i = 1'b1;
    bypassTag_i   = {7'd5, 7'd5, 7'd5, 7'd6};
    bypassData_i  = {64'hB, 64'hC, 64'hA, 64'h100};
    clear_issue();
    test_reset();
    test_add();
    test_bypass();
    test_ops();
    test_throughput();
    test_back_to_back();
    test_flush_at_output();
    test_drain();
    test_drain_abort();
    test_drain_empty();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
